// File: rtl/cfg_if_deser_pkg.sv
// cfg_if_pkg: shared types and default geometry for the config-word deserializer.
package cfg_if_pkg;
    localparam int DEF_PAD_W = 16;
    localparam int DEF_CFG_W = 128;
    localparam int DEF_CNT_W = 8;
    localparam int NUM_BEATS = DEF_CFG_W / DEF_PAD_W;
    localparam int BEAT_CNT_W = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
    typedef enum logic [1:0] {IDLE, FILL, STALL} deser_st_e;
    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cfg_if_deser_if.sv
// cfg_if_deser_if: pad-side beat channel, CCU word channel, flush and status bundle.
interface cfg_if_deser_if #(
    parameter int PAD_W = 16,
    parameter int CFG_W = 128,
    parameter int CNT_W = 8
);
    logic             ASICIF_flush;
    logic             PADIF_val;
    logic [PAD_W-1:0] PADIF_data;
    logic             IFPAD_rdy;
    logic             IFCFG_val;
    logic [CFG_W-1:0] IFCFG_data;
    logic             CFGIF_rdy;
    logic [CNT_W-1:0] IFCCU_word_cnt;
`ifdef CFG_PARITY_EN
    logic             PADIF_par;
    logic             IFERR_parity;
    modport slave (
        input  ASICIF_flush, PADIF_val, PADIF_data, PADIF_par, CFGIF_rdy,
        output IFPAD_rdy, IFCFG_val, IFCFG_data, IFCCU_word_cnt, IFERR_parity
    );
    modport master (
        output ASICIF_flush, PADIF_val, PADIF_data, PADIF_par, CFGIF_rdy,
        input  IFPAD_rdy, IFCFG_val, IFCFG_data, IFCCU_word_cnt, IFERR_parity
    );
`else
    modport slave (
        input  ASICIF_flush, PADIF_val, PADIF_data, CFGIF_rdy,
        output IFPAD_rdy, IFCFG_val, IFCFG_data, IFCCU_word_cnt
    );
    modport master (
        output ASICIF_flush, PADIF_val, PADIF_data, CFGIF_rdy,
        input  IFPAD_rdy, IFCFG_val, IFCFG_data, IFCCU_word_cnt
    );
`endif
endinterface

// File: rtl/cfg_if_deser_par_chk.sv
// cfg_par_chk: per-beat even-parity compare, per-word bad flag and sticky error.
module cfg_par_chk #(
    parameter int PAD_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             beat_acc,
    input  logic             last,
    input  logic [PAD_W-1:0] data,
    input  logic             par,
    output logic             word_bad,
    output logic             err
);
    logic bad_q, bad_d, err_q, err_d, mis;
    assign mis = beat_acc && ((^data) != par);
    // includes the current beat so a bad final beat also drops its word
    assign word_bad = bad_q || mis;
    assign err = err_q;
    always_comb begin
        bad_d = (flush || last) ? 1'b0 : (bad_q || mis);
        err_d = !flush && (err_q || mis);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            err_q <= err_d;
        end
    end
endmodule

// File: rtl/cfg_if_deser.sv
// cfg_if_deser: packs CFG_W/PAD_W pad beats (LSB first) into one CCU config word.
// Optional CFG_PARITY_EN adds per-beat parity checking that drops corrupted words.
module cfg_if_deser
    import cfg_if_pkg::*;
#(
    parameter int PAD_W = DEF_PAD_W,
    parameter int CFG_W = DEF_CFG_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic           clk,
    input logic           rst_n,
    cfg_if_deser_if.slave bus
);
    localparam int NB = CFG_W / PAD_W;
    localparam int BW = cnt_w(NB);
    localparam logic [BW-1:0] LAST = BW'(NB - 1);
    deser_st_e        state_q, state_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CFG_W-1:0] asm_buf_q, asm_buf_d, out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_val_q, out_val_d, init_q;
    logic             pad_rdy, acc, last, drain, load, word_bad;
    assign pad_rdy = init_q && state_q != STALL && !bus.ASICIF_flush;
    assign acc     = bus.PADIF_val && pad_rdy;
    assign last    = acc && beat_cnt_q == LAST;
    assign drain   = out_val_q && bus.CFGIF_rdy;
    // a finished or stalled word moves out whenever the output register is free this edge
    assign load    = ((last && !word_bad) || state_q == STALL) && (!out_val_q || drain);
`ifdef CFG_PARITY_EN
    cfg_par_chk #(.PAD_W(PAD_W)) u_par_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.ASICIF_flush),
        .beat_acc (acc),
        .last     (last),
        .data     (bus.PADIF_data),
        .par      (bus.PADIF_par),
        .word_bad (word_bad),
        .err      (bus.IFERR_parity)
    );
`else
    assign word_bad = 1'b0;
`endif
    always_comb begin
        asm_buf_d = asm_buf_q;
        if (acc) asm_buf_d[int'(beat_cnt_q) * PAD_W +: PAD_W] = bus.PADIF_data;
        beat_cnt_d = acc ? (last ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
        out_val_d  = load || (out_val_q && !drain);
        out_data_d = load ? asm_buf_d : out_data_q;
        cnt_d      = cnt_q + CNT_W'(drain);
        state_d    = (load || (last && word_bad)) ? IDLE :
                     (last || state_q == STALL) ? STALL :
                     acc ? FILL : state_q;
        if (bus.ASICIF_flush) begin
            asm_buf_d  = '0;
            beat_cnt_d = '0;
            out_val_d  = 1'b0;
            out_data_d = '0;
            cnt_d      = '0;
            state_d    = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            asm_buf_q  <= '0;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            cnt_q      <= '0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            asm_buf_q  <= asm_buf_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            init_q     <= 1'b1;
        end
    end
    assign bus.IFPAD_rdy      = pad_rdy;
    assign bus.IFCFG_val      = out_val_q;
    assign bus.IFCFG_data     = out_data_q;
    assign bus.IFCCU_word_cnt = cnt_q;
endmodule
